// File: rtl/gray_conv_arbiter_pkg.sv
// Shared types and constants for the two-channel binary-to-Gray converter.
// Holds the controller state encoding, channel ids and default sizes.
package gray_conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;
    localparam int MAX_WIDTH = 32;

    // Gray back to binary: each bit is the XOR of all Gray bits at or above it.
    // Operands are zero-extended, so the result is valid for any narrower width.
    function automatic logic [MAX_WIDTH-1:0] gray_to_bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b = g;
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_conv_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. The pointer names the channel that wins a
// tie and moves to the other channel whenever a grant is issued.
module rr_arb2
    import gray_conv_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic enable,
    output logic gnt0,
    output logic gnt1
);

    logic ptr_q;
    logic ptr_d;

    // Grant decode and pointer update
    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        ptr_d = ptr_q;
        if (enable) begin
            if (req0 && (!req1 || (ptr_q == CH0))) begin
                gnt0  = 1'b1;
                ptr_d = CH1;
            end else if (req1) begin
                gnt1  = 1'b1;
                ptr_d = CH0;
            end else begin
                ptr_d = ptr_q;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= CH0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Two requesters share one binary-to-Gray datapath; result held under valid/ready.
// Define GRAY_CHECK_EN to add a sticky err output that re-decodes the held result.
module gray_conv_arbiter
    import gray_conv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] bin0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] bin1,
    output logic             ack1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gray,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_id,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
`ifdef GRAY_CHECK_EN
    ,
    output logic             err
`endif
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic               id_q, id_d;
    logic [WIDTH-1:0]   out_gray_q, out_gray_d;
    logic [WIDTH-1:0]   out_bin_q, out_bin_d;
    logic               out_id_q, out_id_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;
    logic               arb_en_s;
    logic               gnt0_s, gnt1_s;

    assign arb_en_s = (state_q == IDLE);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .enable (arb_en_s),
        .gnt0   (gnt0_s),
        .gnt1   (gnt1_s)
    );

    // Controller next state, capture and result generation
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        id_d        = id_q;
        out_gray_d  = out_gray_q;
        out_bin_d   = out_bin_q;
        out_id_d    = out_id_q;
        out_valid_d = out_valid_q;
        done_cnt_d  = done_cnt_q;
        case (state_q)
            IDLE: begin
                if (gnt0_s) begin
                    bin_d   = bin0;
                    id_d    = CH0;
                    state_d = CONV;
                end else if (gnt1_s) begin
                    bin_d   = bin1;
                    id_d    = CH1;
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                out_gray_d  = bin_q ^ (bin_q >> 1);
                out_bin_d   = bin_q;
                out_id_d    = id_q;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + CNT_W'(1'b1);
                    state_d     = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // Controller, capture and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bin_q       <= {WIDTH{1'b0}};
            id_q        <= CH0;
            out_gray_q  <= {WIDTH{1'b0}};
            out_bin_q   <= {WIDTH{1'b0}};
            out_id_q    <= CH0;
            out_valid_q <= 1'b0;
            done_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            id_q        <= id_d;
            out_gray_q  <= out_gray_d;
            out_bin_q   <= out_bin_d;
            out_id_q    <= out_id_d;
            out_valid_q <= out_valid_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign ack0      = gnt0_s;
    assign ack1      = gnt1_s;
    assign out_valid = out_valid_q;
    assign out_gray  = out_gray_q;
    assign out_bin   = out_bin_q;
    assign out_id    = out_id_q;
    assign busy      = (state_q == CONV) || (state_q == HOLD);
    assign done_cnt  = done_cnt_q;

`ifdef GRAY_CHECK_EN
    logic                 err_q, err_d;
    logic [MAX_WIDTH-1:0] chk_bin_s;

    // Decode the held Gray word and latch any disagreement with the source word
    always_comb begin
        chk_bin_s = gray_to_bin(MAX_WIDTH'(out_gray_q));
        err_d     = err_q;
        if ((state_q == HOLD) && (chk_bin_s != MAX_WIDTH'(out_bin_q))) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule
